// File: rtl/frame_bank_pkg.sv
// Shared types and defaults for the triple-buffer frame bank scheduler.
package frame_bank_pkg;

    // Index of one of the three SDRAM frame banks
    typedef logic [1:0] bank_t;

    // Capture gating: wait for sensor init, discard warm-up frames, then run
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSkip = 2'd1,
        StRun  = 2'd2
    } state_e;

    localparam int unsigned DefAddrW    = 24;
    localparam int unsigned DefBankSize = 32'h0004_B000;  // 640x480 RGB565 words

endpackage

// File: rtl/fps_meter.sv
// Completed-frame rate meter: counts frame_done_i pulses per CLK_HZ-cycle window
// and latches the saturated count at each window end. Built only with FRAME_STATS_EN.
module fps_meter #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       restart_i,
    input  logic       frame_done_i,
    output logic [7:0] fps_o
);

    localparam int unsigned WinW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [WinW-1:0] WinLast = WinW'(CLK_HZ - 1);

    logic [WinW-1:0] win_q, win_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      fps_q, fps_d;
    logic [7:0]      cnt_inc;

    // Window and frame counters; the frame count saturates at 255
    always_comb begin
        win_d   = win_q;
        cnt_d   = cnt_q;
        fps_d   = fps_q;
        cnt_inc = (frame_done_i && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
        if (restart_i) begin
            win_d = '0;
            cnt_d = '0;
        end else if (win_q == WinLast) begin
            fps_d = cnt_inc;
            win_d = '0;
            cnt_d = '0;
        end else begin
            win_d = win_q + 1'b1;
            cnt_d = cnt_inc;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q <= '0;
            cnt_q <= '0;
            fps_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
            fps_q <= fps_d;
        end
    end

    assign fps_o = fps_q;

endmodule

// File: rtl/frame_bank_ctrl.sv
// Triple-buffer bank scheduler between capture (SDRAM writer) and LCD (SDRAM reader).
// Optional build macro FRAME_STATS_EN adds the oFPS frame-rate meter; otherwise oFPS is 0.
module frame_bank_ctrl
    import frame_bank_pkg::*;
#(
    parameter int unsigned       ADDR_W      = DefAddrW,
    parameter logic [ADDR_W-1:0] BANK_SIZE   = ADDR_W'(DefBankSize),
    parameter int unsigned       SKIP_FRAMES = 12,
    parameter int unsigned       CLK_HZ      = 100_000_000
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iInit_Done,
    input  logic              iWR_FRAME_START,
    input  logic              iWR_FRAME_END,
    input  logic              iRD_FRAME_START,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_BASE,
    output logic [ADDR_W-1:0] oRD_BASE,
    output logic              oRD_VALID,
    output logic              oFRAME_DROP,
    output logic [7:0]        oFPS
);

    localparam int unsigned SkipW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam logic [SkipW-1:0] SkipLast = SkipW'(SKIP_FRAMES - 1);

    function automatic logic [ADDR_W-1:0] base_of(bank_t b);
        case (b)
            2'd0:    return '0;
            2'd1:    return BANK_SIZE;
            default: return BANK_SIZE << 1;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [SkipW-1:0]  skip_q, skip_d;
    bank_t             wr_q, wr_d, rdy_q, rdy_d, rd_q, rd_d;
    logic              in_frame_q, in_frame_d;
    logic              fresh_q, fresh_d;
    logic              rd_valid_q, rd_valid_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] wr_base_q, rd_base_q;
    logic              end_v;

    // Next-state: gating FSM, bank rotation and drop detection
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        wr_d       = wr_q;
        rdy_d      = rdy_q;
        rd_d       = rd_q;
        in_frame_d = in_frame_q;
        fresh_d    = fresh_q;
        rd_valid_d = rd_valid_q;
        drop_d     = 1'b0;
        end_v      = iWR_FRAME_END && in_frame_q;

        if (!iInit_Done) begin
            // Sensor lost config: stop capture but keep bank ownership intact
            state_d    = StIdle;
            skip_d     = '0;
            in_frame_d = 1'b0;
            fresh_d    = 1'b0;
            rd_valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    skip_d  = '0;
                    state_d = (SKIP_FRAMES == 0) ? StRun : StSkip;
                end
                StSkip: begin
                    if (iWR_FRAME_END) begin
                        if (skip_q == SkipLast) state_d = StRun;
                        else                    skip_d  = skip_q + 1'b1;
                    end
                end
                StRun: begin
                    if (iWR_FRAME_START) begin
                        in_frame_d = 1'b1;
                        // Start without an end: the partial frame restarts in place
                        if (in_frame_q && !end_v) drop_d = 1'b1;
                    end else if (end_v) begin
                        in_frame_d = 1'b0;
                    end
                    if (end_v && iRD_FRAME_START) begin
                        // Finished frame goes straight to the reader; rdy is stale
                        rd_d       = wr_q;
                        wr_d       = rd_q;
                        drop_d     = drop_d | fresh_q;
                        fresh_d    = 1'b0;
                        rd_valid_d = 1'b1;
                    end else if (end_v) begin
                        wr_d    = rdy_q;
                        rdy_d   = wr_q;
                        drop_d  = drop_d | fresh_q;
                        fresh_d = 1'b1;
                    end else if (iRD_FRAME_START && fresh_q) begin
                        rd_d       = rdy_q;
                        rdy_d      = rd_q;
                        fresh_d    = 1'b0;
                        rd_valid_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers; bases come from next-state banks so they track the swap edge
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= StIdle;
            skip_q     <= '0;
            wr_q       <= 2'd0;
            rdy_q      <= 2'd1;
            rd_q       <= 2'd2;
            in_frame_q <= 1'b0;
            fresh_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            wr_base_q  <= base_of(2'd0);
            rd_base_q  <= base_of(2'd2);
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            wr_q       <= wr_d;
            rdy_q      <= rdy_d;
            rd_q       <= rd_d;
            in_frame_q <= in_frame_d;
            fresh_q    <= fresh_d;
            rd_valid_q <= rd_valid_d;
            drop_q     <= drop_d;
            wr_base_q  <= base_of(wr_d);
            rd_base_q  <= base_of(rd_d);
        end
    end

    assign oWR_EN      = in_frame_q;
    assign oWR_BASE    = wr_base_q;
    assign oRD_BASE    = rd_base_q;
    assign oRD_VALID   = rd_valid_q;
    assign oFRAME_DROP = drop_q;

`ifdef FRAME_STATS_EN
    logic frame_done;
    logic run_enter;

    assign frame_done = (state_q == StRun) && iInit_Done && end_v;
    assign run_enter  = (state_q != StRun) && (state_d == StRun);

    fps_meter #(
        .CLK_HZ(CLK_HZ)
    ) u_fps_meter (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .restart_i   (run_enter),
        .frame_done_i(frame_done),
        .fps_o       (oFPS)
    );
`else
    // No meter built; CLK_HZ only matters when the window counter exists
    assign oFPS = 8'(CLK_HZ & 0);
`endif

endmodule
